// File: rtl/coin_payer.sv
`default_nettype none
// ============================================================================
// coin_payer : pays a price in 5c/10c coins, then waits for candy or times out
// Rev 1.0
// ============================================================================
module coin_payer #(
  parameter int TIMEOUT = 8,
  parameter int GAP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] amount,
  input  logic       candy,
  output logic [1:0] coin,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [4:0] paid
);

  localparam int c_GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [c_TW-1:0] c_WAIT_LAST = c_TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_COIN, S_GAP, S_WAIT} state_t;

  state_t          r_state;
  logic [3:0]      r_rem;
  logic [c_GW-1:0] r_gcnt;
  logic [c_TW-1:0] r_wcnt;

  logic [3:0] w_src;
  logic [1:0] w_step;
  logic [3:0] w_rem_next;

  // The coin code doubles as its value in 5c units (01 = 1, 10 = 2).
  assign w_src      = (r_state == S_IDLE) ? amount : r_rem;
  assign w_step     = (w_src >= 4'd2) ? 2'd2 : 2'd1;
  assign w_rem_next = w_src - {2'b00, w_step};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_gcnt  <= '0;
      r_wcnt  <= '0;
      coin    <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      paid    <= '0;
    end else begin
      coin    <= 2'b00;
      done    <= 1'b0;
      timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (amount == 4'd0) begin
              done <= 1'b1;
              paid <= '0;
            end else begin
              coin    <= w_step;
              r_rem   <= w_rem_next;
              paid    <= {3'b000, w_step};
              r_state <= S_COIN;
              busy    <= 1'b1;
            end
          end
        end
        S_COIN: begin
          if (candy) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_rem == 4'd0) begin
            r_wcnt  <= '0;
            r_state <= S_WAIT;
          end else if (GAP == 0) begin
            coin  <= w_step;
            r_rem <= w_rem_next;
            paid  <= paid + {3'b000, w_step};
          end else begin
            r_gcnt  <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (candy) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_gcnt == c_GAP_LAST) begin
            coin    <= w_step;
            r_rem   <= w_rem_next;
            paid    <= paid + {3'b000, w_step};
            r_state <= S_COIN;
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        S_WAIT: begin
          // Candy on the last wait cycle still counts as a delivery.
          if (candy) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_wcnt == c_WAIT_LAST) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
